// File: rtl/alu_vector_checker.sv
// On-chip ALU vector checker: stores test vectors, applies them to an ALU and counts errors.
// Optional first-failure capture ports are enabled by defining ALU_CHECK_FIRST_FAIL_EN.
module alu_vector_checker #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned OP_W   = 4,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned SETTLE = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      wr_en,
   input  logic [ADDR_W-1:0]         wr_addr,
   input  logic [OP_W+3*WIDTH:0]     wr_data,
   input  logic                      start,
   output logic [OP_W-1:0]           dut_aluop,
   output logic [WIDTH-1:0]          dut_a,
   output logic [WIDTH-1:0]          dut_b,
   input  logic [WIDTH-1:0]          dut_result,
   input  logic                      dut_zero,
   output logic                      busy,
   output logic                      done,
   output logic [ADDR_W:0]           vec_cnt,
   output logic [ADDR_W:0]           err_cnt
`ifdef ALU_CHECK_FIRST_FAIL_EN
   ,
   output logic [ADDR_W-1:0]         fail_idx,
   output logic [WIDTH-1:0]          fail_result,
   output logic                      fail_valid
`endif
);

   localparam int unsigned PW = OP_W + 3 * WIDTH;
   localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [2:0] {StIdle, StLoad, StSettle, StCheck, StDone} state_e;

   state_e            state_q, state_d;
   logic [PW-1:0]     payload_q [DEPTH];
   logic [DEPTH-1:0]  valid_q;
   logic [ADDR_W-1:0] idx_q, idx_d, idx_nxt;
   logic [CW-1:0]     settle_q, settle_d;
   logic [WIDTH-1:0]  exp_q;
   logic              load, clear, count, mismatch;

   assign idx_nxt  = idx_q + 1'b1;
   assign mismatch = (dut_result != exp_q) || (dut_zero != (exp_q == '0));
   assign busy     = (state_q == StLoad) || (state_q == StSettle) || (state_q == StCheck);
   assign done     = (state_q == StDone);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      settle_d = settle_q;
      load     = 1'b0;
      clear    = 1'b0;
      count    = 1'b0;
      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StLoad;
               idx_d   = '0;
               clear   = 1'b1;
            end
         end
         StLoad: begin
            load = 1'b1;
            // Only reachable with an invalid slot when slot 0 is empty.
            if (!valid_q[idx_q]) begin
               state_d = StDone;
            end else begin
               state_d  = StSettle;
               settle_d = CW'(SETTLE - 1);
            end
         end
         StSettle: begin
            if (settle_q == '0) state_d = StCheck;
            else                settle_d = settle_q - CW'(1);
         end
         StCheck: begin
            count = 1'b1;
            if ((idx_q == ADDR_W'(DEPTH - 1)) || !valid_q[idx_nxt]) begin
               state_d = StDone;
            end else begin
               idx_d   = idx_nxt;
               state_d = StLoad;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         settle_q  <= '0;
         valid_q   <= '0;
         vec_cnt   <= '0;
         err_cnt   <= '0;
         dut_aluop <= '0;
         dut_a     <= '0;
         dut_b     <= '0;
         exp_q     <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         settle_q <= settle_d;
         if (wr_en && !busy) valid_q[wr_addr] <= wr_data[PW];
         if (clear) begin
            vec_cnt <= '0;
            err_cnt <= '0;
         end else if (count) begin
            vec_cnt <= vec_cnt + 1'b1;
            err_cnt <= err_cnt + {{ADDR_W{1'b0}}, mismatch};
         end
         if (load) {dut_aluop, dut_a, dut_b, exp_q} <= payload_q[idx_q];
      end
   end

   // Payload needs no reset; the valid bits alone gate its use.
   always_ff @(posedge clk) begin
      if (wr_en && !busy) payload_q[wr_addr] <= wr_data[PW-1:0];
   end

`ifdef ALU_CHECK_FIRST_FAIL_EN
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         fail_idx    <= '0;
         fail_result <= '0;
         fail_valid  <= 1'b0;
      end else if (count && mismatch && !fail_valid) begin
         fail_idx    <= idx_q;
         fail_result <= dut_result;
         fail_valid  <= 1'b1;
      end
   end
`else
   // First-failure capture is absent in this build.
`endif

endmodule
